// File: rtl/outport_lock.sv
// Output-port lock: holds the arbiter grant for a wormhole packet, pops the locked
// input's buffer, registers the flit onto the output link and tracks downstream credits.
module outport_lock #(
  parameter int NPORT     = 5,
  parameter int FW        = 32,
  parameter int BUF_DEPTH = 4,
  parameter int CW        = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NPORT-1:0]   grt,
  input  logic [NPORT-1:0]   flit_valid_in,
  input  logic [NPORT-1:0]   flit_tail_in,
  input  logic [NPORT*FW-1:0] flit_in,
  input  logic               credit_in,
  output logic               busy,
  output logic [NPORT-1:0]   sel,
  output logic [NPORT-1:0]   deq,
  output logic               flit_valid_out,
  output logic [FW-1:0]      flit_out,
  output logic [CW-1:0]      credit_cnt,
  output logic               err
);

  localparam logic [0:0]    IDLE    = 1'b0;
  localparam logic [0:0]    LOCKED  = 1'b1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  logic [0:0]       state_r;
  logic [NPORT-1:0] sel_r;
  logic             fvo_r;
  logic [FW-1:0]    fout_r;
  logic [CW-1:0]    cred_r;
  logic             err_r;

  logic [NPORT-1:0] grt_low_s;
  logic             grt_multi_s;
  logic             head_valid_s;
  logic             head_tail_s;
  logic [FW-1:0]    head_flit_s;
  logic             fwd_s;
  logic [CW-1:0]    cred_next_s;
  logic             cred_ovf_s;
  logic             err_set_s;

  // Isolate the lowest set grant bit so a malformed grant still yields a one-hot lock.
  always_comb begin
    grt_low_s   = grt & (~grt + NPORT'(1));
    grt_multi_s = |(grt & (grt - NPORT'(1)));
  end

  // Crossbar: AND-OR mux of the locked input's head-of-buffer flit.
  always_comb begin
    head_valid_s = 1'b0;
    head_tail_s  = 1'b0;
    head_flit_s  = {FW{1'b0}};
    for (int i = 0; i < NPORT; i++) begin
      head_valid_s = head_valid_s | (sel_r[i] & flit_valid_in[i]);
      head_tail_s  = head_tail_s  | (sel_r[i] & flit_tail_in[i]);
      head_flit_s  = head_flit_s  | (flit_in[i*FW +: FW] & {FW{sel_r[i]}});
    end
  end

  // Forward decision; reset suppresses any pop in the reset cycle.
  always_comb begin
    fwd_s = (state_r == LOCKED) & ~rst & head_valid_s & (cred_r != {CW{1'b0}});
  end

  // Credit update; an unsolicited credit at full depth saturates and flags an error.
  always_comb begin
    cred_next_s = cred_r;
    cred_ovf_s  = 1'b0;
    case ({credit_in, fwd_s})
      2'b10: begin
        if (cred_r == DEPTH_C) begin
          cred_ovf_s = 1'b1;
        end else begin
          cred_next_s = cred_r + CW'(1);
        end
      end
      2'b01:   cred_next_s = cred_r - CW'(1);
      default: cred_next_s = cred_r;
    endcase
  end

  // Sticky error sources: credit overflow or a multi-hot grant taken in IDLE.
  always_comb begin
    err_set_s = cred_ovf_s | ((state_r == IDLE) & grt_multi_s);
  end

  // Lock FSM, output link register and credit/error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      sel_r   <= {NPORT{1'b0}};
      fvo_r   <= 1'b0;
      fout_r  <= {FW{1'b0}};
      cred_r  <= DEPTH_C;
      err_r   <= 1'b0;
    end else begin
      fvo_r  <= fwd_s;
      cred_r <= cred_next_s;
      err_r  <= err_r | err_set_s;
      if (fwd_s) begin
        fout_r <= head_flit_s;
      end else begin
        fout_r <= fout_r;
      end
      case (state_r)
        IDLE: begin
          if (|grt) begin
            state_r <= LOCKED;
            sel_r   <= grt_low_s;
          end else begin
            state_r <= IDLE;
            sel_r   <= {NPORT{1'b0}};
          end
        end
        LOCKED: begin
          if (fwd_s & head_tail_s) begin
            state_r <= IDLE;
            sel_r   <= {NPORT{1'b0}};
          end else begin
            state_r <= LOCKED;
            sel_r   <= sel_r;
          end
        end
        default: begin
          state_r <= IDLE;
          sel_r   <= {NPORT{1'b0}};
        end
      endcase
    end
  end

  assign busy           = (state_r == LOCKED);
  assign sel            = sel_r;
  assign deq            = sel_r & {NPORT{fwd_s}};
  assign flit_valid_out = fvo_r;
  assign flit_out       = fout_r;
  assign credit_cnt     = cred_r;
  assign err            = err_r;

endmodule

// File: tb/tb_outport_lock.sv
// Directed plus randomized bench for outport_lock, checked against a packet-level
// model (locked port index, integer credit count, sticky error).
module tb_outport_lock;

  localparam int NPORT = 5;
  localparam int FW    = 32;

  logic               clk;
  logic               rst;
  logic [NPORT-1:0]   grt;
  logic [NPORT-1:0]   fv;
  logic [NPORT-1:0]   ft;
  logic [NPORT*FW-1:0] fin;
  logic               cin;
  logic               busy;
  logic [NPORT-1:0]   sel;
  logic [NPORT-1:0]   deq;
  logic               fvo;
  logic [FW-1:0]      fout;
  logic [2:0]         cred;
  logic               err;

  int vectors;
  int miscompares;

  // reference model state
  int          m_port;
  int          m_cred;
  logic        m_err;
  logic        m_fvo;
  logic [31:0] m_fout;

  outport_lock dut (
    .clk(clk), .rst(rst), .grt(grt), .flit_valid_in(fv), .flit_tail_in(ft),
    .flit_in(fin), .credit_in(cin), .busy(busy), .sel(sel), .deq(deq),
    .flit_valid_out(fvo), .flit_out(fout), .credit_cnt(cred), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] onehot(input int p);
    logic [31:0] v;
    v = 32'd0;
    if (p >= 0) v[p] = 1'b1;
    return v;
  endfunction

  // One clock: check pop pulse, advance model across the edge, check registered outputs.
  task automatic step();
    logic fwd;
    int   lo;
    #1;
    fwd = 1'b0;
    if (m_port >= 0 && !rst) fwd = fv[m_port] && (m_cred > 0);
    chk("deq", {27'd0, deq}, fwd ? onehot(m_port) : 32'd0);
    @(posedge clk);
    if (rst) begin
      m_port = -1; m_cred = 4; m_err = 1'b0; m_fvo = 1'b0; m_fout = 32'd0;
    end else begin
      m_fvo = fwd;
      if (fwd) m_fout = fin[m_port*FW +: FW];
      m_cred = m_cred - (fwd ? 1 : 0) + (cin ? 1 : 0);
      if (m_cred > 4) begin m_cred = 4; m_err = 1'b1; end
      if (m_port < 0) begin
        if (grt != 5'd0) begin
          lo = -1;
          for (int i = NPORT - 1; i >= 0; i--) if (grt[i]) lo = i;
          if ($countones(grt) > 1) m_err = 1'b1;
          m_port = lo;
        end
      end else if (fwd && ft[m_port]) begin
        m_port = -1;
      end
    end
    #1;
    chk("sel",  {27'd0, sel}, onehot(m_port));
    chk("busy", {31'd0, busy}, {31'd0, (m_port >= 0)});
    chk("fvo",  {31'd0, fvo}, {31'd0, m_fvo});
    chk("fout", fout, m_fout);
    chk("cred", {29'd0, cred}, m_cred);
    chk("err",  {31'd0, err}, {31'd0, m_err});
  endtask

  task automatic idle_inputs();
    grt = 5'd0; fv = 5'd0; ft = 5'd0; cin = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    vectors = 0; miscompares = 0;
    m_port = -1; m_cred = 4; m_err = 1'b0; m_fvo = 1'b0; m_fout = 32'd0;
    fin = '0;
    idle_inputs();

    // reset, then 4-flit packet from input 2
    rst = 1'b1; step(); step();
    rst = 1'b0;
    chk("rst_cred", {29'd0, cred}, 32'd4);
    grt = 5'b00100; step();
    grt = 5'd0;
    for (int k = 0; k < 4; k++) begin
      fv[2] = 1'b1; ft[2] = (k == 3); fin[2*FW +: FW] = $urandom; step();
    end
    chk("p1_busy", {31'd0, busy}, 32'd0);
    chk("p1_cred", {29'd0, cred}, 32'd0);
    chk("p1_fvo",  {31'd0, fvo}, 32'd1);
    idle_inputs(); step();

    // restore credits, then 6-flit packet on input 0 with a grant on input 3 while locked
    cin = 1'b1; repeat (4) step();
    idle_inputs(); grt = 5'b00001; step();
    grt = 5'd0;
    for (int k = 0; k < 4; k++) begin
      fv[0] = 1'b1; fin[0 +: FW] = $urandom; step();
    end
    grt = 5'b01000;
    step(); step();
    chk("stall_busy", {31'd0, busy}, 32'd1);
    chk("stall_sel",  {27'd0, sel}, 32'd1);
    chk("stall_fvo",  {31'd0, fvo}, 32'd0);
    chk("stall_err",  {31'd0, err}, 32'd0);
    cin = 1'b1; step();
    cin = 1'b0; fin[0 +: FW] = $urandom; step();
    chk("one_more", {31'd0, fvo}, 32'd1);
    step();
    chk("stall2_fvo", {31'd0, fvo}, 32'd0);
    cin = 1'b1; step();
    cin = 1'b0; ft[0] = 1'b1; fin[0 +: FW] = $urandom; step();
    chk("rel_busy", {31'd0, busy}, 32'd0);
    fv = 5'd0; ft = 5'd0; step();
    chk("g3_sel", {27'd0, sel}, 32'd8);

    // simultaneous credit return and forward at count 2
    grt = 5'd0; cin = 1'b1; step(); step();
    fv[3] = 1'b1; fin[3*FW +: FW] = $urandom; step();
    chk("simul_cred", {29'd0, cred}, 32'd2);
    cin = 1'b0; ft[3] = 1'b1; fin[3*FW +: FW] = $urandom; step();
    idle_inputs(); step();

    // reset in the middle of a packet
    rst = 1'b1; step(); rst = 1'b0;
    grt = 5'b00010; step(); grt = 5'd0;
    fv[1] = 1'b1; fin[FW +: FW] = $urandom; step();
    fin[FW +: FW] = $urandom; step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("mr_sel",  {27'd0, sel}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_cred", {29'd0, cred}, 32'd4);
    chk("mr_fvo",  {31'd0, fvo}, 32'd0);

    // illegal multi-hot grant
    idle_inputs(); grt = 5'b01010; step();
    chk("ill_sel", {27'd0, sel}, 32'd2);
    chk("ill_err", {31'd0, err}, 32'd1);
    grt = 5'd0; step(); step();
    fv[1] = 1'b1; ft[1] = 1'b1; step();
    chk("ill_sticky", {31'd0, err}, 32'd1);
    idle_inputs(); step();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      r = $urandom_range(0, 9);
      if (r < 5) grt = 5'd0;
      else if (r < 9) grt = 5'(onehot($urandom_range(0, 4)));
      else begin r = $urandom; grt = r[4:0]; end
      for (int i = 0; i < NPORT; i++) begin
        fv[i] = ($urandom_range(0, 3) != 0);
        ft[i] = ($urandom_range(0, 3) == 0);
        fin[i*FW +: FW] = $urandom;
      end
      cin = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
